// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared defaults and helpers for the round-robin mux scheduler
// Purpose: default requester count / data width, index-width function and
//          onehot <-> index conversion helpers (widths up to 16 requesters).
package mux_arb_pkg;

    localparam int DEFAULT_N  = 8;
    localparam int DEFAULT_DW = 8;
    localparam int MAX_N      = 16;

    // Index width for n requesters; never below 1 so a 2-lane build still has a bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [MAX_N-1:0] idx2onehot(input logic [3:0] idx);
        return MAX_N'(1) << idx;
    endfunction

    // Lowest set bit wins; an all-zero vector maps to index 0.
    function automatic logic [3:0] onehot2idx(input logic [MAX_N-1:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = MAX_N - 1; i >= 0; i--) begin
            if (oh[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating-priority encoder
// Purpose: picks the first eligible requester searching ptr+1, ptr+2, ... with wrap.
// Ports:
//   eligible in  N   candidate requesters
//   ptr      in  IW  last winner; search starts just after it
//   any      out 1   at least one candidate
//   winner   out IW  chosen index (0 when any=0)
//   onehot   out N   one-hot of winner (0 when any=0)
module rr_pick
    import mux_arb_pkg::*;
#(
    parameter int N  = DEFAULT_N,
    parameter int IW = idx_w(DEFAULT_N)
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] ptr,
    output logic          any,
    output logic [IW-1:0] winner,
    output logic [N-1:0]  onehot
);

    int idx;

    // Walk the search order backwards so the last hit assigned is the first in
    // priority order; avoids a break and keeps the loop a plain mux chain.
    always_comb begin
        any    = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(ptr) + k) % N;
            if (eligible[idx[IW-1:0]]) begin
                any    = 1'b1;
                winner = IW'(idx);
            end
        end
        onehot = any ? N'(idx2onehot(4'(winner))) : '0;
    end

endmodule

// File: rtl/mux_rr_scheduler.sv
// rtl/mux_rr_scheduler.sv - round-robin scheduler with one-entry output buffer for an N:1 mux
// Purpose: shares one output channel between N valid/ready requesters.
// Optional feature macro: MUX_ARB_LOCK_EN (adds lock[N-1:0] to hold priority on the winner).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   en_mask   in  N     requester i may be scheduled
//   req       in  N     per-requester valid
//   req_data  in  N*DW  lane i at [i*DW +: DW]
//   gnt       out N     one-hot ready, combinational
//   lock      in  N     (MUX_ARB_LOCK_EN only) keep priority on the winner
//   out_valid out 1     buffer holds a beat
//   out_data  out DW    buffered beat
//   out_src   out IW    source lane of out_data
//   out_ready in  1     consumer accept
module mux_rr_scheduler
    import mux_arb_pkg::*;
#(
    parameter int  N  = DEFAULT_N,
    parameter int  DW = DEFAULT_DW,
    localparam int IW = idx_w(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  en_mask,
    input  logic [N-1:0]  req,
    input  logic [N*DW-1:0] req_data,
    output logic [N-1:0]  gnt,
`ifdef MUX_ARB_LOCK_EN
    input  logic [N-1:0]  lock,
`endif
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic [IW-1:0] out_src,
    input  logic          out_ready
);

    logic [IW-1:0] ptr;
    logic [IW-1:0] ptr_nxt;
    logic [IW-1:0] winner;
    logic [N-1:0]  eligible;
    logic [N-1:0]  pick_oh;
    logic          any;
    logic          load;

    assign eligible = req & en_mask;

    rr_pick #(.N(N), .IW(IW)) u_pick (
        .eligible (eligible),
        .ptr      (ptr),
        .any      (any),
        .winner   (winner),
        .onehot   (pick_oh)
    );

    // Load when something is eligible and the buffer is empty or draining this cycle.
    assign load = any & (~out_valid | out_ready);
    assign gnt  = (load & rst_n) ? pick_oh : '0;

`ifdef MUX_ARB_LOCK_EN
    // A locked winner parks ptr one behind itself so it stays first in the search.
    assign ptr_nxt = lock[winner] ? ((winner == '0) ? IW'(N - 1) : winner - 1'b1) : winner;
`else
    assign ptr_nxt = winner;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= IW'(N - 1);
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= DW'(req_data >> (int'(winner) * DW));
            out_src   <= winner;
            ptr       <= ptr_nxt;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// tb/tb_mux_rr_scheduler.sv - self-checking bench for mux_rr_scheduler
module tb_mux_rr_scheduler;

    localparam int N  = 8;
    localparam int DW = 8;
    localparam int IW = 3;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  en_mask;
    logic [N-1:0]  req;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]  gnt;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [IW-1:0] out_src;
    logic          out_ready;
`ifdef MUX_ARB_LOCK_EN
    logic [N-1:0]  lock;
`endif

    int n_cmp;
    int n_err;

    // Reference state: what the buffer should hold and who was last served.
    bit        m_valid;
    int        m_data;
    int        m_src;
    int        m_ptr;

    mux_rr_scheduler #(.N(N), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_mask   (en_mask),
        .req       (req),
        .req_data  (req_data),
        .gnt       (gnt),
`ifdef MUX_ARB_LOCK_EN
        .lock      (lock),
`endif
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] e, input int p);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (p + k) % N;
            if (((e >> i) & 1) != 0) return i;
        end
        return -1;
    endfunction

    function automatic int lane(input int w);
        return int'(DW'(req_data >> (w * DW)));
    endfunction

    task automatic model_reset();
        m_valid = 0;
        m_data  = 0;
        m_src   = 0;
        m_ptr   = N - 1;
    endtask

    task automatic set_lane_data();
        for (int k = 0; k < N; k++) req_data[k*DW +: DW] = DW'(8'hA0 + k);
    endtask

    // One clock: check gnt before the edge, advance the model, check the buffer after.
    task automatic cycle();
        int  w;
        bit  ld;
        logic [N-1:0] eg;
        #1;
        w  = pick(req & en_mask, m_ptr);
        ld = (w >= 0) && (!m_valid || out_ready);
        eg = ld ? N'(1 << w) : '0;
        chk("gnt", 32'(gnt), 32'(eg));
        @(posedge clk);
        if (ld) begin
            m_valid = 1;
            m_data  = lane(w);
            m_src   = w;
            m_ptr   = w;
`ifdef MUX_ARB_LOCK_EN
            if (lock[w]) m_ptr = (w + N - 1) % N;
`endif
        end else if (out_ready) begin
            m_valid = 0;
        end
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_data", 32'(out_data), 32'(m_data));
        chk("out_src", 32'(out_src), 32'(m_src));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int rot_exp[4];
        int lk_exp[5];
        int guard;
        n_cmp = 0;
        n_err = 0;
        en_mask   = 8'hFF;
        req       = 8'hFF;
        out_ready = 1'b1;
        req_data  = '0;
`ifdef MUX_ARB_LOCK_EN
        lock = '0;
`endif
        set_lane_data();
        #2;

        // 1: reset and full-request round robin order
        do_reset();
        chk("rst_data", 32'(out_data), 32'h0);
        chk("rst_src", 32'(out_src), 32'h0);
        for (int i = 0; i < 9; i++) begin
            cycle();
            chk("rr_order", 32'(out_src), 32'(i % N));
        end

        // 2: sparse rotation 2,5,7,2
        rot_exp = '{2, 5, 7, 2};
        req = 8'b1010_0100;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("rot_src", 32'(out_src), 32'(rot_exp[i]));
            chk("rot_data", 32'(out_data), 32'(8'hA0 + rot_exp[i]));
        end

        // 3: backpressure holds buffer, then consume+load in one cycle
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_data", 32'(out_data), 32'hA2);
        end
        out_ready = 1'b1;
        cycle();
        chk("bp_release", 32'(out_src), 32'd5);

        // 4: mask; a buffered beat survives its lane being masked
        en_mask = 8'h0F;
        req     = 8'hFF;
        guard   = 0;
        do begin
            cycle();
            chk("mask_range", 32'(out_src < 4), 32'd1);
            guard++;
        end while (!(m_valid && m_src == 1) && guard < 8);
        chk("mask_reach1", 32'(guard < 8), 32'd1);
        out_ready = 1'b0;
        en_mask   = 8'h0D;
        cycle();
        chk("mask_held", 32'(out_src), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("mask_no1", 32'(out_src != 1), 32'd1);
        end

        // 5: asynchronous reset while a beat is buffered
        en_mask = 8'hFF;
        cycle();
        chk("mid_pre_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_async_valid", 32'(out_valid), 32'd0);
        chk("mid_gnt", 32'(gnt), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle();
        chk("mid_restart", 32'(out_src), 32'd0);

        // 6: randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            req       = N'($urandom);
            en_mask   = ($urandom_range(0, 3) == 0) ? N'($urandom) : 8'hFF;
            out_ready = ($urandom_range(0, 2) != 0);
            req_data  = {$urandom, $urandom};
`ifdef MUX_ARB_LOCK_EN
            lock      = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
`endif
            cycle();
        end

`ifdef MUX_ARB_LOCK_EN
        // 7: lock keeps lane 3 on top for a burst of four, then rotation resumes
        set_lane_data();
        en_mask   = 8'hFF;
        out_ready = 1'b1;
        do_reset();
        lk_exp = '{3, 3, 3, 3, 4};
        for (int i = 0; i < 5; i++) begin
            req  = (i == 0) ? 8'h08 : 8'hFF;
            lock = (i < 3) ? 8'h08 : 8'h00;
            cycle();
            chk("lock_src", 32'(out_src), 32'(lk_exp[i]));
        end
`else
        lk_exp = '{0, 0, 0, 0, 0};
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
